// File: rtl/spi_rx_pingpong_ctrl_pkg.sv
// Shared types and sizing for the SPI receive ping-pong buffer manager.
// Optional drop counter is enabled in the top level with SPI_RX_DROP_CNT_EN.
package spi_pp_pkg;

    localparam int PP_DEPTH = 128;
    localparam int PP_AW    = 7;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        DR_IDLE  = 2'd0,
        DR_ISSUE = 2'd1,
        DR_WAIT  = 2'd2
    } drain_state_t;

    // A bank holds a committed frame from FULL until its last byte leaves.
    function automatic logic bank_holds_frame(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/spi_rx_pingpong_ctrl_if.sv
// Bus bundle between the SPI slave / consumer side and the ping-pong controller.
interface spi_rx_pingpong_ctrl_if
    import spi_pp_pkg::*;
#(
    parameter int AW = PP_AW
);

    // Write side: wr_en / wr_finish are single-cycle pulses from the SPI slave.
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_finish;
    logic          wr_ready;

    // Read side: a byte transfers on a clock edge where rd_valid && rd_ready;
    // once rd_valid is high, rd_data/rd_last/rd_len hold until that transfer.
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic [AW:0]   rd_len;

    logic [1:0]    bank_full;
    drain_state_t  drain_state;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_finish, rd_ready,
        output wr_ready, rd_data, rd_valid, rd_last, rd_len, bank_full, drain_state
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_finish, rd_ready,
        input  wr_ready, rd_data, rd_valid, rd_last, rd_len, bank_full, drain_state
    );

endinterface

// File: rtl/spi_rx_pingpong_ctrl_bank.sv
// One DEPTH x 8 buffer bank: single write port, synchronous read port (1-cycle latency).
module spi_pp_bank
    import spi_pp_pkg::*;
#(
    parameter int DEPTH = PP_DEPTH,
    parameter int AW    = PP_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_rx_pingpong_ctrl.sv
// Receive ping-pong manager: fills one bank from the SPI slave while draining the other.
// Define SPI_RX_DROP_CNT_EN to add the saturating drop_cnt output.
module spi_rx_pingpong_ctrl
    import spi_pp_pkg::*;
#(
    parameter int DEPTH = PP_DEPTH,
    parameter int AW    = PP_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_rx_pingpong_ctrl_if.slave bus
`ifdef SPI_RX_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    bank_state_t  bank_q [2];
    bank_state_t  bank_d [2];
    logic         wr_sel_q;
    logic         rd_sel_q;
    logic [AW:0]  cnt_q;
    logic [AW:0]  len_q [2];
    logic [AW:0]  cur_len;

    logic         wr_ready;
    logic         wr_accept;
    logic         wr_store;
    logic         commit;
    logic         drain_start;
    logic         pop;
    logic         last_hs;

    drain_state_t dr_q;
    drain_state_t dr_d;
    logic [AW:0]  nxt_q;
    logic [AW:0]  nxt_d;
    logic         rd_issue;
    logic         issue_last;
    logic [AW-1:0] issue_addr;
    logic         room;
    logic [2:0]   occ;

    logic         pend_q;
    logic         pend_last_q;
    logic [7:0]   bank_rdata [2];
    logic [7:0]   ram_rdata;

    logic [8:0]   fifo_mem [2];
    logic         fifo_wp_q;
    logic         fifo_rp_q;
    logic [1:0]   fifo_cnt_q;
    logic [8:0]   head;
    logic         rd_valid;

    // ---------------- write side ----------------
    assign wr_ready  = (bank_q[wr_sel_q] == BANK_EMPTY) || (bank_q[wr_sel_q] == BANK_FILLING);
    assign wr_accept = bus.wr_en & wr_ready;
    assign wr_store  = wr_accept & (cnt_q != FULL_CNT);
    assign commit    = bus.wr_finish & (bank_q[wr_sel_q] == BANK_FILLING) & (cnt_q != '0);
    assign cur_len   = len_q[rd_sel_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            cnt_q    <= '0;
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else if (commit) begin
            len_q[wr_sel_q] <= cnt_q;
            wr_sel_q        <= ~wr_sel_q;
            cnt_q           <= '0;
        end else if (wr_store) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // ---------------- per-bank state ----------------
    // Write events only touch EMPTY/FILLING banks and read events only FULL/DRAINING
    // ones, so both may land in the same cycle without colliding.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bank_d[i] = bank_q[i];
        end
        if (wr_store) bank_d[wr_sel_q] = BANK_FILLING;
        if (commit) bank_d[wr_sel_q] = BANK_FULL;
        if (drain_start) bank_d[rd_sel_q] = BANK_DRAINING;
        if (last_hs) bank_d[rd_sel_q] = BANK_EMPTY;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) bank_q[i] <= BANK_EMPTY;
            else     bank_q[i] <= bank_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          rd_sel_q <= 1'b0;
        else if (last_hs) rd_sel_q <= ~rd_sel_q;
    end

    // ---------------- drain engine: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dr_q  <= DR_IDLE;
            nxt_q <= '0;
        end else begin
            dr_q  <= dr_d;
            nxt_q <= nxt_d;
        end
    end

    assign drain_start = (dr_q == DR_IDLE) && (bank_q[rd_sel_q] == BANK_FULL);

    // A read may issue only if its word will still fit when it returns next cycle,
    // counting what is queued, what is in flight, and what leaves this cycle.
    assign occ  = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
    assign room = (occ <= 3'd1);

    // ---------------- drain engine: next state ----------------
    always_comb begin
        dr_d  = dr_q;
        nxt_d = nxt_q;
        case (dr_q)
            DR_IDLE: begin
                if (drain_start) begin
                    nxt_d = CNT_ONE;
                    dr_d  = (cur_len == CNT_ONE) ? DR_WAIT : DR_ISSUE;
                end
            end
            DR_ISSUE: begin
                if (room) begin
                    nxt_d = nxt_q + CNT_ONE;
                    if (nxt_q == cur_len - CNT_ONE) dr_d = DR_WAIT;
                end
            end
            DR_WAIT: begin
                if (last_hs) dr_d = DR_IDLE;
            end
            default: dr_d = DR_IDLE;
        endcase
    end

    // ---------------- drain engine: outputs ----------------
    always_comb begin
        rd_issue   = 1'b0;
        issue_addr = nxt_q[AW-1:0];
        issue_last = 1'b0;
        case (dr_q)
            DR_IDLE: begin
                rd_issue   = drain_start;
                issue_addr = '0;
                issue_last = (cur_len == CNT_ONE);
            end
            DR_ISSUE: begin
                rd_issue   = room;
                issue_last = (nxt_q == cur_len - CNT_ONE);
            end
            default: begin
                rd_issue = 1'b0;
            end
        endcase
    end

    // ---------------- bank storage ----------------
    for (genvar g = 0; g < 2; g++) begin : g_bank
        spi_pp_bank #(
            .DEPTH(DEPTH),
            .AW   (AW)
        ) u_bank (
            .clk  (clk),
            .we   (wr_store && (wr_sel_q == 1'(g))),
            .waddr(bus.wr_addr),
            .wdata(bus.wr_data),
            .re   (rd_issue && (rd_sel_q == 1'(g))),
            .raddr(issue_addr),
            .rdata(bank_rdata[g])
        );
    end

    assign ram_rdata = bank_rdata[rd_sel_q];

    // ---------------- read pipeline and 2-entry output FIFO ----------------
    assign rd_valid = (fifo_cnt_q != 2'd0);
    assign head     = fifo_mem[fifo_rp_q];
    assign pop      = rd_valid & bus.rd_ready;
    assign last_hs  = pop & head[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            pend_q      <= rd_issue;
            pend_last_q <= issue_last;
            if (pend_q) begin
                fifo_mem[fifo_wp_q] <= {pend_last_q, ram_rdata};
                fifo_wp_q           <= ~fifo_wp_q;
            end
            if (pop) fifo_rp_q <= ~fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_data     = head[7:0];
    assign bus.rd_last     = rd_valid & head[8];
    assign bus.rd_len      = cur_len;
    assign bus.bank_full   = {bank_holds_frame(bank_q[1]), bank_holds_frame(bank_q[0])};
    assign bus.drain_state = dr_q;

`ifdef SPI_RX_DROP_CNT_EN
    logic       drop_act_q;
    logic       ovf_q;
    logic [7:0] drop_q;
    logic       drop_event;

    // One count per frame: the first refused byte, or the first byte past DEPTH.
    assign drop_event = (bus.wr_en & ~wr_ready & ~drop_act_q) |
                        (wr_accept & (cnt_q == FULL_CNT) & ~ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_act_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            if (bus.wr_finish)                drop_act_q <= 1'b0;
            else if (bus.wr_en && !wr_ready)  drop_act_q <= 1'b1;
            if (commit)                                 ovf_q <= 1'b0;
            else if (wr_accept && (cnt_q == FULL_CNT))  ovf_q <= 1'b1;
            if (drop_event && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_spi_rx_pingpong_ctrl.sv
// Self-checking bench for spi_rx_pingpong_ctrl: frame-level reference model plus stream scoreboard.
module tb_spi_rx_pingpong_ctrl;
    import spi_pp_pkg::*;

    localparam int AW    = PP_AW;
    localparam int DEPTH = PP_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_rx_pingpong_ctrl_if #(.AW(AW)) bus_if ();
`ifdef SPI_RX_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    spi_rx_pingpong_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
`ifdef SPI_RX_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int chk_cnt    = 0;
    int pass_cnt   = 0;
    int held       = 0;   // committed frames not yet fully consumed
    int model_drop = 0;
    logic [16:0] exp_q[$]; // {len, last, data}
    logic [16:0] mon_e;
    logic [7:0]  frame_buf [256];

    // Scoreboard: every valid cycle must present the model's head byte.
    always @(negedge clk) begin
        if (!rst && bus_if.rd_valid) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_extra got data=%02h last=%0b, expected no byte", bus_if.rd_data, bus_if.rd_last);
            end else begin
                mon_e = exp_q[0];
                if ({bus_if.rd_len, bus_if.rd_last, bus_if.rd_data} !== mon_e)
                    $display("FAIL stream_byte got len=%0d last=%0b data=%02h, expected len=%0d last=%0b data=%02h",
                             bus_if.rd_len, bus_if.rd_last, bus_if.rd_data, mon_e[16:9], mon_e[8], mon_e[7:0]);
                else
                    pass_cnt++;
                if (bus_if.rd_ready) begin
                    if (mon_e[8]) held--;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
    endtask

    // Drives a frame of n bytes plus wr_finish; the model accepts it whole if a bank is free.
    task automatic send_frame(input int n);
        int l;
        bit acc;
        l   = (n > DEPTH) ? DEPTH : n;
        acc = (held < 2);
        if (n > 0) begin
            if (acc) begin
                for (int i = 0; i < l; i++) exp_q.push_back({8'(l), 1'(i == l - 1), frame_buf[i]});
                held++;
                if (n > DEPTH) model_drop++;
            end else begin
                model_drop++;
            end
        end
        for (int i = 0; i < n; i++) begin
            bus_if.wr_en   = 1'b1;
            bus_if.wr_addr = (AW)'(i);
            bus_if.wr_data = frame_buf[i];
            tick();
        end
        bus_if.wr_en     = 1'b0;
        bus_if.wr_finish = 1'b1;
        tick();
        bus_if.wr_finish = 1'b0;
    endtask

    task automatic wait_drained(output bit ok);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            tick();
            k++;
        end
        ok = (exp_q.size() == 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_cnt += 6;
        if (bus_if.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b expected 1", bus_if.wr_ready); else pass_cnt++;
        if (bus_if.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b expected 0", bus_if.rd_valid); else pass_cnt++;
        if (bus_if.rd_last !== 1'b0) $display("FAIL reset_rd_last got %b expected 0", bus_if.rd_last); else pass_cnt++;
        if (bus_if.rd_data !== 8'h00) $display("FAIL reset_rd_data got %h expected 00", bus_if.rd_data); else pass_cnt++;
        if (bus_if.rd_len !== 8'd0) $display("FAIL reset_rd_len got %0d expected 0", bus_if.rd_len); else pass_cnt++;
        if (bus_if.bank_full !== 2'b00) $display("FAIL reset_bank_full got %b expected 00", bus_if.bank_full); else pass_cnt++;
`ifdef SPI_RX_DROP_CNT_EN
        chk_cnt++;
        if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d expected 0", drop_cnt); else pass_cnt++;
`endif
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        bit ok;
        logic exp_v;
        bus_if.rd_ready = 1'b1;
        frame_buf[0] = 8'h11; frame_buf[1] = 8'h22; frame_buf[2] = 8'h33; frame_buf[3] = 8'h44;
        send_frame(4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_v = (k >= 3 && k <= 6);
            chk_cnt += 2;
            if (bus_if.rd_valid !== exp_v) $display("FAIL single_valid_k%0d got %b expected %b", k, bus_if.rd_valid, exp_v); else pass_cnt++;
            if (bus_if.wr_ready !== 1'b1) $display("FAIL single_wr_ready_k%0d got %b expected 1", k, bus_if.wr_ready); else pass_cnt++;
            if (k == 1) begin
                chk_cnt++;
                if (bus_if.bank_full !== 2'b01) $display("FAIL single_bank_full got %b expected 01", bus_if.bank_full); else pass_cnt++;
            end
        end
        wait_drained(ok);
        chk_cnt++;
        if (!ok) $display("FAIL single_drain timeout, %0d bytes left", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_two_frames();
        bit ok;
        logic exp_v;
        bus_if.rd_ready = 1'b0;
        fill_random(3); send_frame(3);
        fill_random(5); send_frame(5);
        @(negedge clk);
        chk_cnt += 2;
        if (bus_if.bank_full !== 2'b11) $display("FAIL two_bank_full got %b expected 11", bus_if.bank_full); else pass_cnt++;
        if (bus_if.wr_ready !== 1'b0) $display("FAIL two_wr_ready got %b expected 0", bus_if.wr_ready); else pass_cnt++;
        fill_random(4); send_frame(4);
        @(negedge clk);
`ifdef SPI_RX_DROP_CNT_EN
        chk_cnt++;
        if (drop_cnt !== 8'(model_drop)) $display("FAIL two_drop_cnt got %0d expected %0d", drop_cnt, model_drop); else pass_cnt++;
`endif
        tick();
        bus_if.rd_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            exp_v = (k <= 2) || (k >= 5 && k <= 9);
            chk_cnt++;
            if (bus_if.rd_valid !== exp_v) $display("FAIL two_valid_k%0d got %b expected %b", k, bus_if.rd_valid, exp_v); else pass_cnt++;
        end
        wait_drained(ok);
        @(negedge clk);
        chk_cnt += 3;
        if (!ok) $display("FAIL two_drain timeout, %0d bytes left", exp_q.size()); else pass_cnt++;
        if (bus_if.bank_full !== 2'b00) $display("FAIL two_bank_free got %b expected 00", bus_if.bank_full); else pass_cnt++;
        if (bus_if.wr_ready !== 1'b1) $display("FAIL two_wr_ready_after got %b expected 1", bus_if.wr_ready); else pass_cnt++;
    endtask

    task automatic test_overflow();
        bit ok;
        bus_if.rd_ready = 1'b1;
        fill_random(130);
        send_frame(130);
        wait_drained(ok);
        chk_cnt++;
        if (!ok) $display("FAIL overflow_drain timeout, %0d bytes left", exp_q.size()); else pass_cnt++;
`ifdef SPI_RX_DROP_CNT_EN
        chk_cnt++;
        if (drop_cnt !== 8'(model_drop)) $display("FAIL overflow_drop_cnt got %0d expected %0d", drop_cnt, model_drop); else pass_cnt++;
`endif
    endtask

    task automatic test_zero_finish();
        bit ok;
        bus_if.rd_ready = 1'b1;
        send_frame(0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk_cnt += 3;
            if (bus_if.rd_valid !== 1'b0) $display("FAIL zero_valid_k%0d got %b expected 0", k, bus_if.rd_valid); else pass_cnt++;
            if (bus_if.bank_full !== 2'b00) $display("FAIL zero_bank_full_k%0d got %b expected 00", k, bus_if.bank_full); else pass_cnt++;
            if (bus_if.wr_ready !== 1'b1) $display("FAIL zero_wr_ready_k%0d got %b expected 1", k, bus_if.wr_ready); else pass_cnt++;
        end
        fill_random(1);
        send_frame(1);
        wait_drained(ok);
        chk_cnt++;
        if (!ok) $display("FAIL zero_then_one timeout, %0d bytes left", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_stall_toggle();
        bit ok;
        int k;
        bus_if.rd_ready = 1'b0;
        fill_random(8);
        send_frame(8);
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            bus_if.rd_ready = ~bus_if.rd_ready;
            tick();
            k++;
        end
        bus_if.rd_ready = 1'b1;
        wait_drained(ok);
        @(negedge clk);
        chk_cnt += 2;
        if (!ok) $display("FAIL stall_drain timeout, %0d bytes left", exp_q.size()); else pass_cnt++;
        if (bus_if.rd_valid !== 1'b0) $display("FAIL stall_trailing_valid got %b expected 0", bus_if.rd_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit done;
        bit stuck;
        int n;
        int k;
        int c;
        done  = 1'b0;
        stuck = 1'b0;
        fork
            begin
                for (int f = 0; f < 24; f++) begin
                    k = 0;
                    while (held >= 2 && k < 1000) begin
                        tick();
                        k++;
                    end
                    if (held >= 2) begin
                        stuck = 1'b1;
                        break;
                    end
                    n = $urandom_range(0, 24);
                    fill_random(n);
                    send_frame(n);
                end
                done = 1'b1;
            end
            begin
                c = 0;
                while (!(done && exp_q.size() == 0) && c < 20000) begin
                    tick();
                    bus_if.rd_ready = ($urandom_range(0, 3) != 0);
                    c++;
                end
            end
        join
        bus_if.rd_ready = 1'b1;
        wait_drained(ok);
        @(negedge clk);
        chk_cnt += 4;
        if (stuck || !ok) $display("FAIL b2b_progress got stuck=%0b left=%0d expected stuck=0 left=0", stuck, exp_q.size()); else pass_cnt++;
        if (bus_if.bank_full !== 2'b00) $display("FAIL b2b_bank_free got %b expected 00", bus_if.bank_full); else pass_cnt++;
        if (bus_if.wr_ready !== 1'b1) $display("FAIL b2b_wr_ready got %b expected 1", bus_if.wr_ready); else pass_cnt++;
        if (bus_if.rd_valid !== 1'b0) $display("FAIL b2b_idle_valid got %b expected 0", bus_if.rd_valid); else pass_cnt++;
`ifdef SPI_RX_DROP_CNT_EN
        chk_cnt++;
        if (drop_cnt !== 8'(model_drop)) $display("FAIL b2b_drop_cnt got %0d expected %0d", drop_cnt, model_drop); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        int k;
        bus_if.rd_ready = 1'b1;
        fill_random(10);
        send_frame(10);
        k = 0;
        while (exp_q.size() > 6 && k < 100) begin
            tick();
            k++;
        end
        rst = 1'b1;
        exp_q.delete();
        held       = 0;
        model_drop = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_cnt += 6;
        if (bus_if.wr_ready !== 1'b1) $display("FAIL rstmid_wr_ready got %b expected 1", bus_if.wr_ready); else pass_cnt++;
        if (bus_if.rd_valid !== 1'b0) $display("FAIL rstmid_rd_valid got %b expected 0", bus_if.rd_valid); else pass_cnt++;
        if (bus_if.rd_last !== 1'b0) $display("FAIL rstmid_rd_last got %b expected 0", bus_if.rd_last); else pass_cnt++;
        if (bus_if.rd_data !== 8'h00) $display("FAIL rstmid_rd_data got %h expected 00", bus_if.rd_data); else pass_cnt++;
        if (bus_if.rd_len !== 8'd0) $display("FAIL rstmid_rd_len got %0d expected 0", bus_if.rd_len); else pass_cnt++;
        if (bus_if.bank_full !== 2'b00) $display("FAIL rstmid_bank_full got %b expected 00", bus_if.bank_full); else pass_cnt++;
`ifdef SPI_RX_DROP_CNT_EN
        chk_cnt++;
        if (drop_cnt !== 8'd0) $display("FAIL rstmid_drop_cnt got %0d expected 0", drop_cnt); else pass_cnt++;
`endif
        tick();
        bus_if.rd_ready = 1'b0;
        fill_random(2);
        send_frame(2);
        @(negedge clk);
        chk_cnt++;
        if (bus_if.bank_full !== 2'b01) $display("FAIL rstmid_bank0 got %b expected 01", bus_if.bank_full); else pass_cnt++;
        tick();
        bus_if.rd_ready = 1'b1;
        wait_drained(ok);
        chk_cnt++;
        if (!ok) $display("FAIL rstmid_drain timeout, %0d bytes left", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        bus_if.wr_en     = 1'b0;
        bus_if.wr_addr   = '0;
        bus_if.wr_data   = 8'h00;
        bus_if.wr_finish = 1'b0;
        bus_if.rd_ready  = 1'b0;
        test_reset();
        test_single_frame();
        test_two_frames();
        test_overflow();
        test_zero_finish();
        test_stall_toggle();
        test_back_to_back();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
